mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle MIPS control sequencer. Reads the latched instruction register and walks FETCH/DECODE/EXEC/MEM/WB,
//  driving per-cycle strobes to the shared PC/IR/regfile/ALU/memory datapath. Handshakes with a single shared
//  instruction/data memory port (req/ready). Flags illegal opcodes. Replaces per-instruction combinational ctrl decode.
// PARAMETERS
//  ALU_OP_W         4   width of alu_op bus (encodings from mips_pkg)
//  TRAP_ON_ILLEGAL  1   1: illegal opcode -> TRAP (halt); 0: treat as NOP, return to FETCH
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  ir         in   32  instruction register contents (valid from DECODE onward)
//  alu_zero   in   1   ALU zero flag, combinational from current ALU inputs
//  mem_ready  in   1   memory completes current access this cycle
//  mem_req    out  1   memory access request, held until mem_ready
//  mem_we     out  1   write access (with mem_req)
//  iord       out  1   0: mem addr = PC, 1: mem addr = ALUOut
//  ir_we      out  1   load IR from memory read data
//  pc_we      out  1   load PC
//  pc_src     out  2   0: ALU result (PC+4), 1: ALUOut (branch target), 2: jump {PC[31:28],ir[25:0],2'b00}
//  reg_we     out  1   register file write
//  reg_dst    out  1   0: rt, 1: rd
//  wb_sel     out  1   0: ALUOut, 1: memory data register
//  alu_src_a  out  1   0: PC, 1: rs
//  alu_src_b  out  2   0: rt, 1: const 4, 2: extended imm, 3: sext imm<<2
//  ext_sel    out  1   0: sign-extend, 1: zero-extend immediate
//  alu_op     out  ALU_OP_W  ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 LUI=6
//  illegal    out  1   sticky, set on undecodable instruction
//  state_o    out  4   current state encoding (debug)
// BEHAVIOUR
//  - Reset: state=FETCH; every strobe 0, alu_op=ADD, pc_src=0, illegal=0. Reset asserted mid-access drops mem_req
//    at once (async); first post-reset cycle is FETCH with mem_req=1.
//  - Supported: R-type 000000 funct add 100000, sub 100010, and 100100, or 100101, slt 101010; addi 001000,
//    andi 001100, ori 001101, xori 001110, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
//    andi/ori/xori zero-extend; addi/lw/sw/beq sign-extend.
//  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD. ir_we=pc_we=mem_ready (Mealy), pc_src=0.
//    Stay while mem_ready=0; ->DECODE when 1.
//  - DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target into ALUOut). Next: R->EXEC_R, imm ALU->EXEC_I,
//    lw/sw->MEM_ADDR, beq->BRANCH, j->JUMP, else illegal: set illegal, ->TRAP (or FETCH if TRAP_ON_ILLEGAL=0).
//    Unknown R funct is illegal.
//  - EXEC_R: src_a=1, src_b=0, alu_op from funct ->ALU_WB. EXEC_I: src_a=1, src_b=2, alu_op from opcode ->ALU_WB.
//  - ALU_WB: reg_we=1, wb_sel=0, reg_dst=1 for R else 0 ->FETCH.
//  - MEM_ADDR: src_a=1, src_b=2, ADD, ext_sel=0; lw->MEM_RD, sw->MEM_WR.
//  - MEM_RD: mem_req=1, iord=1; wait on mem_ready ->MEM_WB. MEM_WB: reg_we=1, wb_sel=1, reg_dst=0 ->FETCH.
//  - MEM_WR: mem_req=1, mem_we=1, iord=1; wait on mem_ready ->FETCH.
//  - BRANCH: src_a=1, src_b=0, SUB; pc_src=1, pc_we=alu_zero ->FETCH.
//  - JUMP: pc_we=1, pc_src=2 ->FETCH.
//  - TRAP: all strobes 0, remains until reset; illegal stays 1.
//  - Latency with 0 wait states (mem_ready=1 first cycle of access): R/imm 4, lw 5, sw 4, beq 3, j 3 cycles;
//    each memory wait cycle adds 1. mem_req/mem_we/iord stable across waits; no strobe other than these
//    during a wait.
//  - mem_ready outside a requesting state is ignored.
// STRUCTURE
//  - mips_pkg: opcode/funct localparams, ALU op codes, pc_src/alu_src_b codes, state enum (4-bit).
//  - Sub-module alu_decode: combinational {opcode,funct} -> {alu_op, ext_sel, legal}; FSM instantiates it once.
//  - FSM: one registered state + illegal flag; outputs decoded from state (Mealy only on mem_ready, alu_zero).
// TESTING
//  - Reset: rst_n=0 mid-MEM_RD -> mem_req=0 immediately; after release state_o=FETCH, mem_req=1, illegal=0.
//  - addi (0x20010005), mem_ready=1 -> FETCH,DECODE,EXEC_I,ALU_WB; reg_we=1 reg_dst=0 in cycle 4; ext_sel=0.
//  - lw (0x8C220004), 2 wait states in MEM_RD -> mem_req&iord held 3 cycles, reg_we+wb_sel=1 in MEM_WB, 7 cycles.
//  - beq (0x10220003): alu_zero=1 -> pc_we=1 pc_src=1 in BRANCH; alu_zero=0 -> pc_we=0; both back to FETCH.
//  - ori (0x34213000) -> ext_sel=1, alu_op=OR; R sub funct 100010 -> alu_op=SUB, reg_dst=1.
//  - Illegal opcode 0xFC000000 -> illegal=1, state TRAP, no mem_req thereafter until reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// ALU operations, datapath mux selects, sequencer states and instruction classes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_AND = 2;
    localparam int ALU_OR  = 3;
    localparam int ALU_XOR = 4;
    localparam int ALU_SLT = 5;
    localparam int ALU_LUI = 6;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

    localparam logic [1:0] SRC_B_RT   = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;
    localparam logic [1:0] SRC_B_BOFS = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_IMM = 3'd1,
        CLS_MEM = 3'd2,
        CLS_BEQ = 3'd3,
        CLS_J   = 3'd4,
        CLS_ILL = 3'd5
    } inst_class_t;

endpackage

// File: rtl/mc_control_fsm_alu_decode.sv
// Combinational instruction decode: classifies {opcode,funct} and picks the
// ALU operation and immediate extension used in the execute cycle.
module alu_decode
    import mips_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                ext_sel,
    output logic                legal,
    output inst_class_t         iclass
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        alu_op  = ALU_OP_W'(ALU_ADD);
        ext_sel = 1'b0;
        iclass  = CLS_ILL;
        case (opcode)
            OP_RTYPE: begin
                iclass = CLS_R;
                case (funct)
                    FN_ADD:  alu_op = ALU_OP_W'(ALU_ADD);
                    FN_SUB:  alu_op = ALU_OP_W'(ALU_SUB);
                    FN_AND:  alu_op = ALU_OP_W'(ALU_AND);
                    FN_OR:   alu_op = ALU_OP_W'(ALU_OR);
                    FN_SLT:  alu_op = ALU_OP_W'(ALU_SLT);
                    default: iclass = CLS_ILL;
                endcase
            end
            OP_ADDI: begin
                iclass = CLS_IMM;
                alu_op = ALU_OP_W'(ALU_ADD);
            end
            OP_ANDI: begin
                iclass  = CLS_IMM;
                alu_op  = ALU_OP_W'(ALU_AND);
                ext_sel = 1'b1;
            end
            OP_ORI: begin
                iclass  = CLS_IMM;
                alu_op  = ALU_OP_W'(ALU_OR);
                ext_sel = 1'b1;
            end
            OP_XORI: begin
                iclass  = CLS_IMM;
                alu_op  = ALU_OP_W'(ALU_XOR);
                ext_sel = 1'b1;
            end
            OP_LUI: begin
                iclass = CLS_IMM;
                alu_op = ALU_OP_W'(ALU_LUI);
            end
            OP_LW, OP_SW: iclass = CLS_MEM;
            OP_BEQ: begin
                iclass = CLS_BEQ;
                alu_op = ALU_OP_W'(ALU_SUB);
            end
            OP_J:    iclass = CLS_J;
            default: iclass = CLS_ILL;
        endcase
    end

    assign legal = (iclass != CLS_ILL);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer: walks FETCH/DECODE/EXEC/MEM/WB and drives
// per-cycle datapath strobes plus the shared memory req/ready handshake.
module mc_control_fsm
    import mips_pkg::*;
#(
    parameter int ALU_OP_W        = 4,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         ir,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                reg_we,
    output logic                reg_dst,
    output logic                wb_sel,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                ext_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic [3:0]          state_o
);

    state_t                state;
    logic [ALU_OP_W-1:0]   dec_alu_op;
    logic                  dec_ext_sel;
    logic                  dec_legal;
    inst_class_t           dec_class;
    logic                  unused_ir;

    assign unused_ir = ^{ir[25:6], dec_legal};

    alu_decode #(.ALU_OP_W(ALU_OP_W)) u_alu_decode (
        .opcode  (ir[31:26]),
        .funct   (ir[5:0]),
        .alu_op  (dec_alu_op),
        .ext_sel (dec_ext_sel),
        .legal   (dec_legal),
        .iclass  (dec_class)
    );

    // NOTE: state and the sticky flag are registers, so they take non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (dec_class)
                        CLS_R:   state <= S_EXEC_R;
                        CLS_IMM: state <= S_EXEC_I;
                        CLS_MEM: state <= S_MEM_ADDR;
                        CLS_BEQ: state <= S_BRANCH;
                        CLS_J:   state <= S_JUMP;
                        default: begin
                            illegal <= 1'b1;
                            state   <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                        end
                    endcase
                end
                S_EXEC_R, S_EXEC_I: state <= S_ALU_WB;
                S_MEM_ADDR: state <= (ir[31:26] == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
                S_MEM_WR:   if (mem_ready) state <= S_FETCH;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode the current state; gating on rst_n drops mem_req the instant reset asserts.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_SEQ;
        reg_we    = 1'b0;
        reg_dst   = 1'b0;
        wb_sel    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRC_B_RT;
        ext_sel   = 1'b0;
        alu_op    = ALU_OP_W'(ALU_ADD);
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_DECODE: alu_src_b = SRC_B_BOFS;
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = dec_alu_op;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = dec_alu_op;
                    ext_sel   = dec_ext_sel;
                end
                S_ALU_WB: begin
                    reg_we  = 1'b1;
                    reg_dst = (ir[31:26] == OP_RTYPE);
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEM_WB: begin
                    reg_we = 1'b1;
                    wb_sel = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_W'(ALU_SUB);
                    pc_src    = PC_SRC_BR;
                    pc_we     = alu_zero;
                end
                S_JUMP: begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_JMP;
                end
                default: ;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by cycle
// against hand-computed strobe values.
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0]  pc_src;
    logic        reg_we, reg_dst, wb_sel, alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ext_sel;
    logic [3:0]  alu_op;
    logic        illegal;
    logic [3:0]  state_o;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
                           ALU_WB = 4'd4, MEM_ADDR = 4'd5, MEM_RD = 4'd6, MEM_WB = 4'd7,
                           MEM_WR = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, TRAP = 4'd11;

    mc_control_fsm #(.ALU_OP_W(4), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir        (ir),
        .alu_zero  (alu_zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wb_sel    (wb_sel),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .ext_sel   (ext_sel),
        .alu_op    (alu_op),
        .illegal   (illegal),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then drive this cycle's inputs well away from the edge.
    task automatic step(input logic mr, input logic az);
        @(posedge clk);
        #1;
        mem_ready = mr;
        alu_zero  = az;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ir = 32'h0; alu_zero = 1'b0; mem_ready = 1'b1;
        #22;
        check("rst_state",   32'(state_o), 32'(FETCH));
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_pc_we",   32'(pc_we),   32'd0);
        check("rst_alu_op",  32'(alu_op),  32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        // addi: FETCH, DECODE, EXEC_I, ALU_WB
        @(posedge clk); #1;
        rst_n = 1'b1; ir = 32'h20010005; mem_ready = 1'b1; #1;
        check("addi_f_state", 32'(state_o), 32'(FETCH));
        check("addi_f_req",   32'(mem_req), 32'd1);
        check("addi_f_srcb",  32'(alu_src_b), 32'd1);
        check("addi_f_irwe",  32'(ir_we), 32'd1);
        check("addi_f_pcwe",  32'(pc_we), 32'd1);
        step(1'b1, 1'b0);
        check("addi_d_state", 32'(state_o), 32'(DECODE));
        check("addi_d_srcb",  32'(alu_src_b), 32'd3);
        check("addi_d_req",   32'(mem_req), 32'd0);
        step(1'b1, 1'b0);
        check("addi_x_state", 32'(state_o), 32'(EXEC_I));
        check("addi_x_srcab", 32'({alu_src_a, alu_src_b}), 32'b110);
        check("addi_x_ext",   32'(ext_sel), 32'd0);
        check("addi_x_aluop", 32'(alu_op), 32'd0);
        step(1'b1, 1'b0);
        check("addi_wb_state", 32'(state_o), 32'(ALU_WB));
        check("addi_wb_strb",  32'({reg_we, reg_dst, wb_sel}), 32'b100);
        step(1'b1, 1'b0);
        check("addi_back", 32'(state_o), 32'(FETCH));

        // lw with two wait states in MEM_RD: 7 cycles total
        ir = 32'h8C220004;
        step(1'b1, 1'b0);
        check("lw_d_state", 32'(state_o), 32'(DECODE));
        step(1'b1, 1'b0);
        check("lw_a_state", 32'(state_o), 32'(MEM_ADDR));
        check("lw_a_req_ignored", 32'(mem_req), 32'd0);
        check("lw_a_srcb", 32'(alu_src_b), 32'd2);
        for (int w = 0; w < 3; w++) begin
            step(w == 2, 1'b0);
            check($sformatf("lw_rd%0d_state", w), 32'(state_o), 32'(MEM_RD));
            check($sformatf("lw_rd%0d_req_iord", w), 32'({mem_req, iord, mem_we}), 32'b110);
            check($sformatf("lw_rd%0d_quiet", w), 32'({reg_we, pc_we, ir_we}), 32'd0);
        end
        step(1'b0, 1'b0);
        check("lw_wb_state", 32'(state_o), 32'(MEM_WB));
        check("lw_wb_strb",  32'({reg_we, wb_sel, reg_dst}), 32'b110);
        step(1'b0, 1'b0);
        check("lw_back", 32'(state_o), 32'(FETCH));

        // beq taken then not taken
        ir = 32'h10220003;
        mem_ready = 1'b1; #1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("beq1_state", 32'(state_o), 32'(BRANCH));
        check("beq1_pc",    32'({pc_we, pc_src}), 32'b101);
        check("beq1_aluop", 32'(alu_op), 32'd1);
        step(1'b1, 1'b0);
        check("beq1_back", 32'(state_o), 32'(FETCH));
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("beq0_state", 32'(state_o), 32'(BRANCH));
        check("beq0_pcwe",  32'(pc_we), 32'd0);
        step(1'b1, 1'b0);
        check("beq0_back", 32'(state_o), 32'(FETCH));

        // ori: zero-extended immediate, OR
        ir = 32'h34213000;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("ori_state", 32'(state_o), 32'(EXEC_I));
        check("ori_ext",   32'(ext_sel), 32'd1);
        check("ori_aluop", 32'(alu_op), 32'd3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("ori_back", 32'(state_o), 32'(FETCH));

        // R-type sub
        ir = 32'h00221822;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("sub_state", 32'(state_o), 32'(EXEC_R));
        check("sub_aluop", 32'(alu_op), 32'd1);
        check("sub_srcab", 32'({alu_src_a, alu_src_b}), 32'b100);
        step(1'b1, 1'b0);
        check("sub_wb", 32'({reg_we, reg_dst}), 32'b11);
        step(1'b1, 1'b0);
        check("sub_back", 32'(state_o), 32'(FETCH));

        // sw with one wait state
        ir = 32'hAC220004;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("sw_wait_state", 32'(state_o), 32'(MEM_WR));
        check("sw_wait_strb",  32'({mem_req, mem_we, iord}), 32'b111);
        step(1'b1, 1'b0);
        check("sw_done_strb",  32'({mem_req, mem_we, iord}), 32'b111);
        step(1'b0, 1'b0);
        check("sw_back", 32'(state_o), 32'(FETCH));
        check("fetch_wait_irwe", 32'({ir_we, pc_we, mem_req}), 32'b001);

        // j
        ir = 32'h08000010;
        step(1'b1, 1'b0);
        check("j_wait_held", 32'(state_o), 32'(FETCH));
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("j_state", 32'(state_o), 32'(JUMP));
        check("j_pc",    32'({pc_we, pc_src}), 32'b110);
        step(1'b1, 1'b0);
        check("j_back", 32'(state_o), 32'(FETCH));

        // illegal opcode traps and stops requesting memory
        ir = 32'hFC000000;
        step(1'b1, 1'b0);
        check("ill_pre", 32'(illegal), 32'd0);
        step(1'b1, 1'b0);
        check("ill_state", 32'(state_o), 32'(TRAP));
        check("ill_flag",  32'(illegal), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0);
            check($sformatf("trap%0d", k), 32'({state_o, mem_req, illegal}), 32'({TRAP, 1'b0, 1'b1}));
        end

        // reset mid-MEM_RD
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        rst_n = 1'b1; ir = 32'h8C220004; mem_ready = 1'b1; #1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("rr_in_memrd", 32'({state_o, mem_req}), 32'({MEM_RD, 1'b1}));
        #2;
        rst_n = 1'b0; #1;
        check("rr_req_drop", 32'(mem_req), 32'd0);
        check("rr_state",    32'(state_o), 32'(FETCH));
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        check("rr_post", 32'({state_o, mem_req, illegal}), 32'({FETCH, 1'b1, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
